// File: rtl/quantum_pkg.sv
// quantum_pkg: shared constants and FSM state type for the measurement
// reconstruction slice.
//   AMP_W       amplitude width (signed Q1.15)
//   CNT_W       outcome histogram count width
//   TOT_W       width of the sum of all four counts
//   PROB_W      probability scale exponent (2^30 == 1.0)
//   NUM_BASIS   number of basis states (|00>,|01>,|10>,|11>)
//   DIV_CYCLES  restoring-divider iterations per basis state
//   SQRT_CYCLES square-root iterations per basis state
package quantum_pkg;

  localparam int unsigned AMP_W       = 16;
  localparam int unsigned CNT_W       = 11;
  localparam int unsigned TOT_W       = 13;
  localparam int unsigned PROB_W      = 30;
  localparam int unsigned NUM_BASIS   = 4;
  localparam int unsigned DIV_CYCLES  = 31;
  localparam int unsigned SQRT_CYCLES = 16;

  localparam logic [AMP_W-1:0] AMP_MAX = 16'h7FFF;

  typedef enum logic [2:0] {
    IDLE,
    SUM,
    DIV,
    SQRT,
    STORE,
    FIN
  } recon_state_t;

  // Saturate a 17-bit root (possibly rounded up) to the largest Q1.15 value.
  function automatic logic [AMP_W-1:0] clamp_amp(input logic [AMP_W:0] v);
    if (v > {1'b0, AMP_MAX}) return AMP_MAX;
    else                     return v[AMP_W-1:0];
  endfunction

endpackage

// File: rtl/recon_divsqrt.sv
// recon_divsqrt: sequential datapath for one basis state.
//   Divider : q = (count << 30) / total, 31 iterations while div_en=1.
//   Sqrt    : digit-by-digit root of q, 16 iterations while sqrt_en=1.
//   Both share one iteration counter; the first iteration of each phase
//   seeds itself from its inputs, so no separate load cycle is needed.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   div_en, sqrt_en phase enables from the top FSM (mutually exclusive)
//   count, total    latched count of the current basis state and the sum
//   last            high during the final iteration of the active phase
//   amp_val         clamped (and optionally rounded) root, valid after sqrt
// Configuration: define RECON_ROUND_EN to round the root to nearest.
module recon_divsqrt
  import quantum_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             div_en,
  input  logic             sqrt_en,
  input  logic [CNT_W-1:0] count,
  input  logic [TOT_W-1:0] total,
  output logic             last,
  output logic [AMP_W-1:0] amp_val
);

  logic [4:0]          iter;
  logic [TOT_W-1:0]    div_rem;
  logic [PROB_W:0]     quo;
  logic [2*AMP_W-1:0]  rad;
  logic [AMP_W:0]      srem;
  logic [AMP_W-1:0]    root;

  // Divider step. Dividend is count<<30; the leading ten iterations of a
  // full-width divide would only shift count>>1 in (it is always < total),
  // so the first real iteration starts from count>>1 and feeds count[0].
  logic [TOT_W-1:0] d_base;
  logic             d_bit;
  logic [TOT_W:0]   d_trial;
  logic             d_ge;
  logic [TOT_W-1:0] d_next;

  always_comb begin
    d_base  = (iter == '0) ? TOT_W'(count >> 1) : div_rem;
    d_bit   = (iter == '0) ? count[0] : 1'b0;
    d_trial = {d_base, d_bit};
    d_ge    = (d_trial >= {1'b0, total});
    d_next  = d_ge ? TOT_W'(d_trial - {1'b0, total}) : d_trial[TOT_W-1:0];
  end

  // Square-root step: two radicand bits per iteration, MSB pair first.
  logic [2*AMP_W-1:0] s_src;
  logic [AMP_W:0]     s_rem_base;
  logic [AMP_W-1:0]   s_root_base;
  logic [AMP_W+2:0]   s_shift;
  logic [AMP_W+2:0]   s_trial;
  logic               s_ge;

  always_comb begin
    s_src       = (iter == '0) ? {1'b0, quo} : rad;
    s_rem_base  = (iter == '0) ? '0 : srem;
    s_root_base = (iter == '0) ? '0 : root;
    s_shift     = {s_rem_base, s_src[2*AMP_W-1 -: 2]};
    s_trial     = {1'b0, s_root_base, 2'b01};
    s_ge        = (s_shift >= s_trial);
  end

  always_comb begin
    last = 1'b0;
    if (div_en  && (iter == 5'(DIV_CYCLES - 1)))  last = 1'b1;
    if (sqrt_en && (iter == 5'(SQRT_CYCLES - 1))) last = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iter    <= '0;
      div_rem <= '0;
      quo     <= '0;
      rad     <= '0;
      srem    <= '0;
      root    <= '0;
    end else begin
      if (div_en || sqrt_en) iter <= last ? '0 : iter + 5'd1;
      else                   iter <= '0;

      if (div_en) begin
        div_rem <= d_next;
        quo     <= {quo[PROB_W-1:0], d_ge};
      end

      if (sqrt_en) begin
        rad  <= s_src << 2;
        srem <= s_ge ? (AMP_W+1)'(s_shift - s_trial) : s_shift[AMP_W:0];
        root <= {s_root_base[AMP_W-2:0], s_ge};
      end
    end
  end

`ifdef RECON_ROUND_EN
  // Remainder above root means q >= (root+0.5)^2, so the nearest integer
  // root is one higher.
  assign amp_val = clamp_amp({1'b0, root} + ((srem > {1'b0, root}) ? 17'd1 : 17'd0));
`else
  assign amp_val = clamp_amp({1'b0, root});
`endif

endmodule

// File: rtl/state_reconstruct.sv
// state_reconstruct: estimates real amplitudes of a two-qubit state from
// measurement histograms: amp_k = sqrt(count_k * 2^30 / total), clamped to
// 32767. Latency is 194 cycles from the start edge to done (2 if total=0).
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   start                    request; sampled only while idle
//   count0..count3           outcome counts for |00>,|01>,|10>,|11>
//   amp00_real..amp11_real   Q1.15 amplitudes, updated together at done
//   amp00_imag..amp11_imag   always zero
//   busy                     reconstruction in progress
//   done                     one-cycle completion pulse
//   err                      sticky until next start: counts summed to zero
// Configuration: define RECON_ROUND_EN to round roots to nearest instead of
// truncating (handled in recon_divsqrt; latency unchanged).
module state_reconstruct
  import quantum_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count0,
  input  logic [CNT_W-1:0] count1,
  input  logic [CNT_W-1:0] count2,
  input  logic [CNT_W-1:0] count3,
  output logic [AMP_W-1:0] amp00_real,
  output logic [AMP_W-1:0] amp01_real,
  output logic [AMP_W-1:0] amp10_real,
  output logic [AMP_W-1:0] amp11_real,
  output logic [AMP_W-1:0] amp00_imag,
  output logic [AMP_W-1:0] amp01_imag,
  output logic [AMP_W-1:0] amp10_imag,
  output logic [AMP_W-1:0] amp11_imag,
  output logic             busy,
  output logic             done,
  output logic             err
);

  recon_state_t     state;
  logic [CNT_W-1:0] cnt_lat [NUM_BASIS];
  logic [AMP_W-1:0] shadow  [NUM_BASIS];
  logic [AMP_W-1:0] amp_q   [NUM_BASIS];
  logic [TOT_W-1:0] total;
  logic [TOT_W-1:0] sum_c;
  logic [1:0]       k;
  logic             div_en;
  logic             sqrt_en;
  logic             last;
  logic [AMP_W-1:0] amp_val;

  assign div_en  = (state == DIV);
  assign sqrt_en = (state == SQRT);
  assign sum_c   = TOT_W'(cnt_lat[0]) + TOT_W'(cnt_lat[1])
                 + TOT_W'(cnt_lat[2]) + TOT_W'(cnt_lat[3]);

  recon_divsqrt u_divsqrt (
    .clk     (clk),
    .reset   (reset),
    .div_en  (div_en),
    .sqrt_en (sqrt_en),
    .count   (cnt_lat[k]),
    .total   (total),
    .last    (last),
    .amp_val (amp_val)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      total <= '0;
      k     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      for (int unsigned i = 0; i < NUM_BASIS; i++) begin
        cnt_lat[i] <= '0;
        shadow[i]  <= '0;
        amp_q[i]   <= '0;
      end
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            cnt_lat[0] <= count0;
            cnt_lat[1] <= count1;
            cnt_lat[2] <= count2;
            cnt_lat[3] <= count3;
            // Shadows are cleared here so a zero-total run publishes zeros.
            for (int unsigned i = 0; i < NUM_BASIS; i++) shadow[i] <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= SUM;
          end
        end
        SUM: begin
          total <= sum_c;
          k     <= '0;
          if (sum_c == '0) begin
            err   <= 1'b1;
            state <= FIN;
          end else begin
            state <= DIV;
          end
        end
        DIV: begin
          if (last) state <= SQRT;
        end
        SQRT: begin
          if (last) state <= STORE;
        end
        STORE: begin
          shadow[k] <= amp_val;
          if (k == 2'(NUM_BASIS - 1)) begin
            state <= FIN;
          end else begin
            k     <= k + 2'd1;
            state <= DIV;
          end
        end
        FIN: begin
          for (int unsigned i = 0; i < NUM_BASIS; i++) amp_q[i] <= shadow[i];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign amp00_real = amp_q[0];
  assign amp01_real = amp_q[1];
  assign amp10_real = amp_q[2];
  assign amp11_real = amp_q[3];
  assign amp00_imag = '0;
  assign amp01_imag = '0;
  assign amp10_imag = '0;
  assign amp11_imag = '0;

endmodule

// File: tb/tb_state_reconstruct.sv
// tb_state_reconstruct: randomized and directed self-checking bench for
// state_reconstruct. Expected amplitudes come from a real-arithmetic model
// of sqrt(count * 2^30 / total) corrected to the exact integer floor.
module tb_state_reconstruct;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] count0, count1, count2, count3;
  logic [15:0] amp00_real, amp01_real, amp10_real, amp11_real;
  logic [15:0] amp00_imag, amp01_imag, amp10_imag, amp11_imag;
  logic        busy, done, err;

  int n_vec = 0;
  int n_err = 0;

  longint exp_amp [4];
  bit     exp_err;

  always #5 clk = ~clk;

  state_reconstruct dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .count0     (count0),
    .count1     (count1),
    .count2     (count2),
    .count3     (count3),
    .amp00_real (amp00_real),
    .amp01_real (amp01_real),
    .amp10_real (amp10_real),
    .amp11_real (amp11_real),
    .amp00_imag (amp00_imag),
    .amp01_imag (amp01_imag),
    .amp10_imag (amp10_imag),
    .amp11_imag (amp11_imag),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic check(input string tag, input longint got, input longint expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  function automatic longint model_amp(input longint c, input longint tot);
    longint p, r;
    if (tot == 0) return 0;
    p = (c << 30) / tot;
    r = longint'($floor($sqrt(real'(p))));
    while (r * r > p) r--;
    while ((r + 1) * (r + 1) <= p) r++;
`ifdef RECON_ROUND_EN
    if (p - r * r > r) r++;
`endif
    if (r > 32767) r = 32767;
    return r;
  endfunction

  function automatic longint amp_at(input int i);
    case (i)
      0:       return longint'(amp00_real);
      1:       return longint'(amp01_real);
      2:       return longint'(amp10_real);
      default: return longint'(amp11_real);
    endcase
  endfunction

  task automatic check_outputs(input string pfx);
    for (int i = 0; i < 4; i++) check($sformatf("%s_amp%0d", pfx, i), amp_at(i), exp_amp[i]);
    check({pfx, "_err"}, err, exp_err);
    check({pfx, "_imag"}, {amp00_imag, amp01_imag, amp10_imag, amp11_imag}, 0);
  endtask

  // One reconstruction: start sampled at the first posedge after the call.
  // mid_start > 0 raises start for one cycle that many cycles into the run.
  task automatic run_op(input logic [10:0] c0, input logic [10:0] c1,
                        input logic [10:0] c2, input logic [10:0] c3,
                        input int mid_start, input bit rel_reset);
    int     cyc;
    int     exp_lat;
    longint tot;
    bit     seen;
    tot     = longint'(c0) + longint'(c1) + longint'(c2) + longint'(c3);
    exp_lat = (tot == 0) ? 2 : 194;
    exp_amp[0] = model_amp(c0, tot);
    exp_amp[1] = model_amp(c1, tot);
    exp_amp[2] = model_amp(c2, tot);
    exp_amp[3] = model_amp(c3, tot);
    exp_err    = (tot == 0);

    @(negedge clk);
    if (rel_reset) reset = 1'b0;
    count0 = c0; count1 = c1; count2 = c2; count3 = c3;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    // Counts are only meaningful at the start edge.
    count0 = 11'($urandom); count1 = 11'($urandom);
    count2 = 11'($urandom); count3 = 11'($urandom);
    check("busy_after_start", busy, 1);

    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == mid_start);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    check("latency", cyc, exp_lat);
    check("busy_at_done", busy, 0);
    check_outputs("run");
  endtask

  task automatic hold_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      count0 = 11'($urandom); count1 = 11'($urandom);
      check("hold_done", done, 0);
      check("hold_busy", busy, 0);
      check_outputs("hold");
    end
  endtask

  initial begin
    int mode;
    logic [10:0] rc [4];

    reset = 1'b1; start = 1'b0;
    count0 = '0; count1 = '0; count2 = '0; count3 = '0;
    exp_amp = '{0, 0, 0, 0};
    exp_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check_outputs("rst");

    // Start honoured on the very first edge with reset low.
    run_op(11'd1000, 11'd0, 11'd0, 11'd0, 0, 1'b1);
    check("c1000_amp00", amp00_real, 32767);
    hold_idle(3);

    run_op(11'd250, 11'd250, 11'd250, 11'd250, 0, 1'b0);
    check("quarter_amp11", amp11_real, 16384);
    run_op(11'd1, 11'd1, 11'd0, 11'd2, 0, 1'b0);
    check("c1102_amp11", amp11_real, 23170);
    run_op(11'd1, 11'd2, 11'd0, 11'd0, 0, 1'b0);
`ifdef RECON_ROUND_EN
    check("c12_amp00", amp00_real, 18919);
    check("c12_amp01", amp01_real, 26755);
`else
    check("c12_amp00", amp00_real, 18918);
    check("c12_amp01", amp01_real, 26754);
`endif
    hold_idle(2);

    // Zero total right after a nonzero run: outputs must return to zero.
    run_op(11'd0, 11'd0, 11'd0, 11'd0, 0, 1'b0);
    hold_idle(2);

    // Back-to-back, then a start pulse mid-run that must be ignored.
    run_op(11'd2047, 11'd2047, 11'd2047, 11'd2047, 0, 1'b0);
    run_op(11'd300, 11'd100, 11'd0, 11'd600, 50, 1'b0);
    hold_idle(3);

    // Reset in the middle of a run.
    @(negedge clk);
    count0 = 11'd5; count1 = 11'd7; count2 = 11'd9; count3 = 11'd11;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    exp_amp = '{0, 0, 0, 0};
    exp_err = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check_outputs("abort");
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_done", done, 0);
    end
    run_op(11'd3, 11'd0, 11'd12, 11'd1, 0, 1'b1);

    // Randomized counts: full range, small values, and sparse patterns.
    for (int t = 0; t < 16; t++) begin
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < 4; i++) begin
        case (mode)
          0:       rc[i] = 11'($urandom_range(0, 2047));
          1:       rc[i] = 11'($urandom_range(0, 3));
          default: rc[i] = ($urandom_range(0, 1) == 0) ? 11'd0 : 11'($urandom_range(1, 2047));
        endcase
      end
      run_op(rc[0], rc[1], rc[2], rc[3], 0, 1'b0);
      if (t % 4 == 3) hold_idle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/state_reconstruct.md
STATE_RECONSTRUCT -- requirements
Module: state_reconstruct

Interface
REQ-001 The block SHALL have ports: clk  in  1  system clock, rising edge; reset  in  1  asynchronous, active-high.
REQ-002 The block SHALL have ports: start  in  1  request reconstruction; count0..count3  in  11 each  outcome histograms for |00>,|01>,|10>,|11>, unsigned.
REQ-003 The block SHALL have ports: amp00_real..amp11_real  out  16 each  signed Q1.15 amplitude estimates; amp00_imag..amp11_imag  out  16 each  signed, constant 0.
REQ-004 The block SHALL have ports: busy  out  1  reconstruction in progress; done  out  1  one-cycle completion pulse; err  out  1  sticky "total count zero" flag.

Function
REQ-005 The block SHALL compute amp_k = floor(sqrt(count_k * 2^30 / total)), clamped to 32767, with total = sum of the four counts (13-bit).
REQ-006 Probability scale SHALL be 2^30 = 1.0, so that amp^2 sums to about 2^30, matching the 30-bit sampling scale of the measurement block.
REQ-007 FSM states SHALL be IDLE, SUM, DIV, SQRT, STORE, FIN.
REQ-008 In IDLE, with start=1 at a rising edge, the block SHALL latch all four counts, clear err, set busy, and go to SUM.
REQ-009 SUM SHALL form total in 1 cycle; if total=0 -> FIN with err=1; otherwise -> DIV with index k=0.
REQ-010 DIV SHALL be a restoring divider, 31 cycles, quotient p_k (31 bits) = (count_k<<30)/total, remainder discarded.
REQ-011 SQRT SHALL be a digit-by-digit integer square root, 16 cycles, producing a 16-bit root and remainder.
REQ-012 STORE SHALL take 1 cycle: clamp to 32767, write the shadow register k; if k<3 then k++ -> DIV; otherwise -> FIN.
REQ-013 FIN SHALL take 1 cycle: copy all four shadows to the amp outputs simultaneously, pulse done, clear busy, -> IDLE.
REQ-014 done SHALL rise exactly 194 cycles after the start-sampling edge when total≠0, and exactly 2 cycles after it when total=0.
REQ-015 The total=0 path SHALL set all amp outputs to 0.
REQ-016 start SHALL be ignored while busy=1.
REQ-017 Count input changes after latching SHALL have no effect.
REQ-018 amp outputs SHALL hold their values between done pulses.
REQ-019 The block SHALL accept start in the cycle immediately after done (back-to-back operation).
REQ-020 All imag outputs SHALL be constantly 0.

Reset
REQ-021 Reset SHALL force IDLE and clear all amp outputs, all shadow registers, busy, done, err and k, asynchronously.
REQ-022 Reset asserted mid-operation SHALL abort the run: no done pulse, and the outputs SHALL read 0.
REQ-023 The first start after reset deassertion SHALL be honoured on the first rising edge with reset low.

Configuration
REQ-024 Macro RECON_ROUND_EN defined: STORE SHALL round to nearest: if sqrt remainder > root then root+1, then clamp to 32767; latency unchanged.
REQ-025 Macro RECON_ROUND_EN undefined: root SHALL be truncated (floor), then clamped to 32767.

Structure
REQ-026 Shared package quantum_pkg SHALL hold: AMP_W=16, CNT_W=11, PROB_W=30, NUM_BASIS=4, DIV_CYCLES=31, SQRT_CYCLES=16, and the FSM state enum type.
REQ-027 The sub-module recon_divsqrt SHALL hold the sequential divider and square-root datapath (one shared iteration counter), driven by the top FSM.
REQ-028 The top level SHALL hold the FSM, the count latches, the shadow registers and the outputs.

Verification
REQ-029 counts=1000,0,0,0 -> amp00_real=32767 (sqrt 32768 clamped), others 0, err=0, done at cycle 194.
REQ-030 counts=250,250,250,250 -> all amp_real=16384.
REQ-031 counts=1,1,0,2 -> 16384,16384,0,23170, both with and without RECON_ROUND_EN.
REQ-032 counts=1,2,0,0 -> without macro 18918,26754,0,0; with RECON_ROUND_EN 18919,26755,0,0.
REQ-033 counts all 0 -> err=1, all amps 0, done 2 cycles after start.
REQ-034 Start pulse at cycle 50 of a run -> ignored, single done at cycle 194.
REQ-035 Reset at cycle 100 -> busy=0, no done pulse, outputs 0, next start completes normally.
